// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle processor: sequences each instruction through
// its states and drives datapath selects plus the unconditional write strobes.
module multicycle_ctrl_fsm (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       NoWrite,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [3:0] State
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;

    logic [3:0] state_q, state_d;
    logic [1:0] alu_ctrl_dec;
    logic [1:0] flagw_dec;
    logic       nowrite_dec;
    logic       rd_is_pc;

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD: state_d = MEMWB;
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    // Data-processing decode; CMP and unsupported commands both suppress the register write.
    always_comb begin
        alu_ctrl_dec = 2'b00;
        flagw_dec    = 2'b00;
        nowrite_dec  = 1'b0;
        case (Funct[4:1])
            4'b0100: begin alu_ctrl_dec = 2'b00; flagw_dec = {Funct[0], Funct[0]}; end
            4'b0010: begin alu_ctrl_dec = 2'b01; flagw_dec = {Funct[0], Funct[0]}; end
            4'b0000: begin alu_ctrl_dec = 2'b10; flagw_dec = {Funct[0], 1'b0}; end
            4'b1100: begin alu_ctrl_dec = 2'b11; flagw_dec = {Funct[0], 1'b0}; end
            4'b1010: begin alu_ctrl_dec = 2'b01; flagw_dec = 2'b11; nowrite_dec = 1'b1; end
            default: begin alu_ctrl_dec = 2'b00; flagw_dec = 2'b00; nowrite_dec = 1'b1; end
        endcase
    end

    assign rd_is_pc = (Rd == 4'b1111);

    always_comb begin
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        FlagW      = 2'b00;
        NoWrite    = 1'b0;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:  ALUSrcB = 2'b01;
            MEMREAD: AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                PCS       = rd_is_pc;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            // Flags are only written in the execute cycle, when ALUFlags are valid.
            EXECR, EXECI: begin
                ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_ctrl_dec;
                FlagW      = flagw_dec;
                NoWrite    = nowrite_dec;
            end
            ALUWB: begin
                RegW    = 1'b1;
                NoWrite = nowrite_dec;
                PCS     = rd_is_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCS       = 1'b1;
            end
            default: ;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle expected state and outputs are
// queued when an instruction is issued and compared each cycle on the falling edge.
module tb_multicycle_ctrl_fsm;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] Op = 2'b11;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic       PCS, RegW, MemW, NoWrite, IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] outs;
    } exp_t;

    exp_t sb[$];

    multicycle_ctrl_fsm dut (
        .CLK(CLK), .RESET(RESET), .Op(Op), .Funct(Funct), .Rd(Rd),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .NoWrite(NoWrite),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .State(State)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] outs_now();
        return {PCS, RegW, MemW, FlagW, NoWrite, IRWrite, NextPC,
                AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl};
    endfunction

    // Reference model, organised per output signal.
    function automatic logic [15:0] model(input logic [3:0] st, input logic [5:0] fn,
                                          input logic [3:0] rd);
        logic       pcs, regw, memw, nw, irw, npc, adr, srca;
        logic [1:0] fw, ac, rs, srcb, fw_d, ac_d;
        logic       nw_d;
        case (fn[4:1])
            4'b0100: begin ac_d = 2'b00; fw_d = {fn[0], fn[0]}; nw_d = 1'b0; end
            4'b0010: begin ac_d = 2'b01; fw_d = {fn[0], fn[0]}; nw_d = 1'b0; end
            4'b0000: begin ac_d = 2'b10; fw_d = {fn[0], 1'b0};  nw_d = 1'b0; end
            4'b1100: begin ac_d = 2'b11; fw_d = {fn[0], 1'b0};  nw_d = 1'b0; end
            4'b1010: begin ac_d = 2'b01; fw_d = 2'b11;          nw_d = 1'b1; end
            default: begin ac_d = 2'b00; fw_d = 2'b00;          nw_d = 1'b1; end
        endcase
        pcs  = (st == 4'd9) || ((st == 4'd4 || st == 4'd8) && rd == 4'hF);
        regw = (st == 4'd4) || (st == 4'd8);
        memw = (st == 4'd5);
        fw   = (st == 4'd6 || st == 4'd7) ? fw_d : 2'b00;
        nw   = (st == 4'd6 || st == 4'd7 || st == 4'd8) ? nw_d : 1'b0;
        irw  = (st == 4'd0);
        npc  = (st == 4'd0);
        adr  = (st == 4'd3) || (st == 4'd5);
        rs   = (st == 4'd4) ? 2'b01 :
               (st == 4'd0 || st == 4'd1 || st == 4'd9) ? 2'b10 : 2'b00;
        srca = (st == 4'd0) || (st == 4'd1);
        srcb = (st == 4'd0 || st == 4'd1) ? 2'b10 :
               (st == 4'd2 || st == 4'd7 || st == 4'd9) ? 2'b01 : 2'b00;
        ac   = (st == 4'd6 || st == 4'd7) ? ac_d : 2'b00;
        return {pcs, regw, memw, fw, nw, irw, npc, adr, rs, srca, srcb, ac};
    endfunction

    // Called on a falling edge with the FSM in FETCH; leaves on the falling edge where
    // the FSM should be back in FETCH. stop_at cuts the sequence short (for reset tests).
    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input logic [3:0] seq[$], input int stop_at);
        exp_t e;
        Op = op; Funct = fn; Rd = rd;
        foreach (seq[i]) begin
            if (i < stop_at) begin
                e.st = seq[i];
                e.outs = model(seq[i], fn, rd);
                sb.push_back(e);
            end
        end
        for (int i = 0; sb.size() > 0; i++) begin
            if (i > 0) @(negedge CLK);
            e = sb.pop_front();
            chk({name, "_state"}, {28'd0, State}, {28'd0, e.st});
            chk({name, "_outs"}, {16'd0, outs_now()}, {16'd0, e.outs});
        end
        if (stop_at >= seq.size()) @(negedge CLK);
    endtask

    initial begin
        // Reset held for two cycles.
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_state", {28'd0, State}, 32'd0);
        chk("rst_irw_npc", {30'd0, IRWrite, NextPC}, 32'd3);
        chk("rst_srcb", {30'd0, ALUSrcB}, 32'd2);
        chk("rst_strobes", {29'd0, PCS, RegW, MemW}, 32'd0);
        @(negedge CLK);
        chk("rst_state2", {28'd0, State}, 32'd0);
        RESET = 1'b0;

        run_instr("ldr",    2'b01, 6'b011001, 4'b0011, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 99);
        run_instr("str",    2'b01, 6'b011000, 4'b0011, '{4'd0, 4'd1, 4'd2, 4'd5}, 99);
        run_instr("adds",   2'b00, 6'b001001, 4'b0010, '{4'd0, 4'd1, 4'd6, 4'd8}, 99);
        run_instr("cmpi",   2'b00, 6'b110101, 4'b0000, '{4'd0, 4'd1, 4'd7, 4'd8}, 99);
        run_instr("addpc",  2'b00, 6'b001000, 4'b1111, '{4'd0, 4'd1, 4'd6, 4'd8}, 99);
        run_instr("ands",   2'b00, 6'b000001, 4'b0100, '{4'd0, 4'd1, 4'd6, 4'd8}, 99);
        run_instr("orri",   2'b00, 6'b111000, 4'b0101, '{4'd0, 4'd1, 4'd7, 4'd8}, 99);
        run_instr("orrs",   2'b00, 6'b011001, 4'b0101, '{4'd0, 4'd1, 4'd6, 4'd8}, 99);
        run_instr("subs",   2'b00, 6'b000101, 4'b0110, '{4'd0, 4'd1, 4'd6, 4'd8}, 99);
        run_instr("sub",    2'b00, 6'b000100, 4'b0110, '{4'd0, 4'd1, 4'd6, 4'd8}, 99);
        run_instr("badcmd", 2'b00, 6'b011111, 4'b0111, '{4'd0, 4'd1, 4'd6, 4'd8}, 99);
        run_instr("b",      2'b10, 6'b000000, 4'b0000, '{4'd0, 4'd1, 4'd9}, 99);
        run_instr("nop",    2'b11, 6'b000000, 4'b0000, '{4'd0, 4'd1}, 99);
        run_instr("ldrpc",  2'b01, 6'b011001, 4'b1111, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 99);

        // Reset pulsed with the FSM sitting in MEMREAD.
        run_instr("ldr_rst", 2'b01, 6'b011001, 4'b0011, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 4);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midrst_state", {28'd0, State}, 32'd0);
        chk("midrst_wr", {30'd0, RegW, MemW}, 32'd0);
        RESET = 1'b0;

        run_instr("post_b", 2'b10, 6'b000000, 4'b0000, '{4'd0, 4'd1, 4'd9}, 99);
        chk("final_state", {28'd0, State}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle processor variant; sits directly upstream of the conditional-execution logic.
- Produces the unconditional strobes PCS, RegW, MemW, FlagW and NoWrite that the conditional logic gates with the condition check.
- Also drives datapath mux selects, IR/PC enables and ALUControl, decoded from Op/Funct/Rd of the latched instruction.

Parameters:
- None. State encoding is fixed, listed under Behaviour.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20]: I, cmd[3:0], S/L.
- Rd  in  4  instruction bits [15:12].
- PCS  out  1  PC-write request (branch, or write to R15).
- RegW  out  1  register-write request.
- MemW  out  1  memory-write request.
- FlagW  out  2  [1]=NZ write, [0]=CV write.
- NoWrite  out  1  suppress register write (CMP or unsupported cmd).
- IRWrite  out  1  latch instruction register.
- NextPC  out  1  PC <= PC+4.
- AdrSrc  out  1  0=PC, 1=ALU result as memory address.
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult.
- ALUSrcA  out  1  0=RD1, 1=PC.
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- State  out  4  current state, for debug and verification.

Behaviour:
- Synchronous, active-high reset: on RESET=1 at posedge, State <= FETCH(0). This applies from any state, including mid-instruction.
- Outputs are combinational from State plus Funct/Rd (Moore with instruction decode). No output registers.
- Every output not listed for a state is 0.
- States, outputs, and next state:
  - FETCH(0): AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1, ADD. Next: DECODE.
  - DECODE(1): ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD. Next by Op:
    - 01 -> MEMADR
    - 00 with Funct[5]=0 -> EXECR
    - 00 with Funct[5]=1 -> EXECI
    - 10 -> BRANCH
    - 11 -> FETCH (treated as NOP, no strobes)
  - MEMADR(2): ALUSrcA=0, ALUSrcB=01, ADD. Next: MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD(3): AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWB(4): ResultSrc=01, RegW=1. Next: FETCH.
  - MEMWRITE(5): AdrSrc=1, ResultSrc=00, MemW=1. Next: FETCH.
  - EXECR(6): ALUSrcA=0, ALUSrcB=00, ALU-decode active. Next: ALUWB.
  - EXECI(7): ALUSrcA=0, ALUSrcB=01, ALU-decode active. Next: ALUWB.
  - ALUWB(8): ResultSrc=00, RegW=1, NoWrite from decode. Next: FETCH.
  - BRANCH(9): ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD, PCS=1. Next: FETCH.
  - Encodings 10-15: all outputs 0. Next: FETCH.
- ALU decode, on cmd=Funct[4:1] and S=Funct[0]:
  - 0100 ADD: ALUControl=00, FlagW={S,S}.
  - 0010 SUB: ALUControl=01, FlagW={S,S}.
  - 0000 AND: ALUControl=10, FlagW={S,0}.
  - 1100 ORR: ALUControl=11, FlagW={S,0}.
  - 1010 CMP: ALUControl=01, FlagW=11 regardless of S, NoWrite=1.
  - Any other cmd: ALUControl=00, FlagW=00, NoWrite=1.
- FlagW is nonzero only in EXECR/EXECI, the cycle in which ALUFlags are valid. It is 00 in all other states.
- NoWrite is driven from the decode in EXECR, EXECI and ALUWB. It is 0 elsewhere.
- PCS = 1 in BRANCH, and in MEMWB/ALUWB when Rd=1111. It is 0 otherwise.
- Instruction latency from FETCH to the next FETCH:
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Data-processing: 4 cycles.
  - B: 3 cycles.
  - Op=11: 2 cycles.
- Op/Funct/Rd must be stable from DECODE onward; the IR guarantees this. The FSM never samples them in FETCH.

Test Plan:
- RESET=1 for 2 cycles, then released -> State=0, IRWrite=1, NextPC=1, ALUSrcB=10, and PCS=RegW=MemW=0 during reset.
- LDR (Op=01, Funct=011001, Rd=0011) -> State sequence 0,1,2,3,4,0. RegW=1 and ResultSrc=01 only in state 4. PCS=0.
- STR (Op=01, Funct=011000) -> sequence 0,1,2,5,0. MemW=1 and AdrSrc=1 only in state 5. RegW=0 throughout.
- ADDS reg (Op=00, Funct=001001, Rd=0010) -> sequence 0,1,6,8,0. FlagW=11 and ALUControl=00 in state 6. RegW=1, NoWrite=0 in state 8.
- CMP imm (Op=00, Funct=110101) -> sequence 0,1,7,8,0. ALUControl=01, FlagW=11 in state 7. NoWrite=1 in state 8.
- ADD with Rd=1111 -> PCS=1 in state 8.
- B (Op=10) -> sequence 0,1,9,0 with PCS=1 in state 9.
- RESET pulsed while in state 3 -> State=0 on the next edge and MemW/RegW never asserted.
